// File: rtl/bla_sub_pkg.sv
// bla_sub_pkg: shared types and constants for the nibble-serial subtractor
package bla_sub_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;
  typedef logic [3:0] nibble_t;
endpackage

// File: rtl/bla_nibble.sv
// bla_nibble: combinational 4-bit borrow-lookahead subtract slice
module bla_nibble
  import bla_sub_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);
  nibble_t p, g, bi;
  assign p = ~(x ^ y);
  assign g = ~x & y;
  assign bi[0] = bin;
  assign bi[1] = g[0] | (p[0] & bin);
  assign bi[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign bi[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
  assign bout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bin);
  assign d = x ^ y ^ bi;
endmodule

// File: rtl/bla_serial_subtractor.sv
// bla_serial_subtractor: nibble-serial a - b with borrow lookahead; define BLA_SUB_OVERFLOW_EN for the ovf output
module bla_serial_subtractor
  import bla_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef BLA_SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);
  localparam int N  = WIDTH / NIBBLE_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  if (WIDTH % NIBBLE_W != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $fatal(1, "WIDTH must be a positive multiple of 4");
  end
  sub_state_t st;
  logic [CW-1:0] cnt;
  logic bin_r, bout, last;
  logic [WIDTH-1:0] ash, bsh, res, nxt;
  logic [WIDTH+NIBBLE_W-1:0] cat;
  nibble_t d;
  bla_nibble u_nib (.x(ash[3:0]), .y(bsh[3:0]), .bin(bin_r), .d(d), .bout(bout));
  assign cat  = {d, res};
  assign nxt  = cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
  assign last = cnt == CW'(N - 1);
  // handshake FSM: capture operands, shift one nibble per RUN cycle, hold result in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef BLA_SUB_OVERFLOW_EN
      ovf        <= 1'b0;
`endif
      cnt        <= '0;
      bin_r      <= 1'b0;
      ash        <= '0;
      bsh        <= '0;
      res        <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          ash      <= a;
          bsh      <= b;
          bin_r    <= 1'b0;
          cnt      <= '0;
          in_ready <= 1'b0;
          st       <= RUN;
        end
        RUN: begin
          ash   <= ash >> NIBBLE_W;
          bsh   <= bsh >> NIBBLE_W;
          res   <= nxt;
          bin_r <= bout;
          cnt   <= cnt + 1'b1;
          if (last) begin
            st         <= DONE;
            out_valid  <= 1'b1;
            diff       <= nxt;
            borrow_out <= bout;
`ifdef BLA_SUB_OVERFLOW_EN
            ovf        <= (ash[3] != bsh[3]) & (d[3] != ash[3]);
`endif
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          st        <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bla_serial_subtractor.sv
// tb_bla_serial_subtractor: randomized self-checking bench against an arithmetic reference
module tb_bla_serial_subtractor;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, borrow_out;
  logic [15:0] a = '0, b = '0, diff;
`ifdef BLA_SUB_OVERFLOW_EN
  logic ovf;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  bla_serial_subtractor #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .diff(diff),
`ifdef BLA_SUB_OVERFLOW_EN
    .ovf(ovf),
`endif
    .borrow_out(borrow_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic op(input logic [15:0] x, input logic [15:0] y, input int stall);
    int n, sd;
    logic [15:0] ed;
    logic eb;
    ed = 16'((32'(x) + 32'h10000 - 32'(y)) % 32'h10000);
    eb = x < y;
    sd = int'($signed(x)) - int'($signed(y));
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_idle", in_ready, 1);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_busy", in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, 4);
    check("diff", diff, ed);
    check("borrow", borrow_out, eb);
`ifdef BLA_SUB_OVERFLOW_EN
    check("ovf", ovf, (sd > 32767 || sd < -32768) ? 1 : 0);
`endif
    for (int i = 0; i < stall; i++) begin
      a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_diff", diff, ed);
      check("hold_borrow", borrow_out, eb);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask
  initial begin
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    op(16'h1234, 16'h0234, 0);
    a = 16'h1111; b = 16'h0101; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_diff", diff, 0);
    check("midrst_borrow", borrow_out, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    op(16'h0005, 16'h0003, 0);
    op(16'h0000, 16'h0001, 0);
    op(16'hA5A5, 16'hA5A5, 0);
    op(16'hFFFF, 16'h0000, 1);
    op(16'h9ABC, 16'h1234, 5);
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] x, y;
      x = 16'($urandom);
      y = ($urandom_range(0, 15) == 0) ? x : 16'($urandom);
      op(x, y, int'($urandom_range(0, 3)));
    end
`ifdef BLA_SUB_OVERFLOW_EN
    op(16'h8000, 16'h0001, 0);
    op(16'h0003, 16'h0001, 0);
    op(16'h7FFF, 16'hFFFF, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
